// File: rtl/modn_prog_counter_pkg.sv
// Shared encodings for the programmable modulo-N counter family.
package modn_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/modn_prog_counter_if.sv
// Control/status bundle of the modulo-N counter: the master drives control, the slave returns status.
interface modn_prog_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] max_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tc;
    logic             err;

    modport master (
        output en, mode, max_val, load, load_val,
        input  count, dir, tc, err
    );

    modport slave (
        input  en, mode, max_val, load, load_val,
        output count, dir, tc, err
    );
endinterface

// File: rtl/modn_prog_counter_step.sv
// Combinational next-step of the counter for one enabled edge; wrap_o marks a wrap or reflection.
module modn_step
    import modn_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             dir_o,
    output logic             wrap_o
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic at_max;
    logic at_zero;
    logic max_zero;

    assign at_max   = (count_i == max_val_i);
    assign at_zero  = (count_i == '0);
    assign max_zero = (max_val_i == '0);

    always_comb begin
        count_o = count_i;
        dir_o   = dir_i;
        wrap_o  = 1'b0;
        // A count stranded above a lowered max_val restarts from zero in every counting mode.
        if (mode_i != MODE_HOLD && count_i > max_val_i) begin
            count_o = '0;
            wrap_o  = 1'b1;
            dir_o   = (mode_i == MODE_DOWN) ? DIR_DOWN : DIR_UP;
        end else begin
            case (mode_i)
                MODE_UP: begin
                    dir_o = DIR_UP;
                    if (at_max) begin
                        count_o = '0;
                        wrap_o  = 1'b1;
                    end else begin
                        count_o = count_i + ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_o = DIR_DOWN;
                    if (at_zero) begin
                        count_o = max_val_i;
                        wrap_o  = 1'b1;
                    end else begin
                        count_o = count_i - ONE;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_i == DIR_UP) begin
                        if (at_max) begin
                            count_o = max_zero ? '0 : max_val_i - ONE;
                            dir_o   = DIR_DOWN;
                            wrap_o  = 1'b1;
                        end else begin
                            count_o = count_i + ONE;
                        end
                    end else begin
                        if (at_zero) begin
                            count_o = max_zero ? '0 : ONE;
                            dir_o   = DIR_UP;
                            wrap_o  = 1'b1;
                        end else begin
                            count_o = count_i - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/modn_prog_counter.sv
// Programmable modulo-N up/down/bounce counter with synchronous load, registered tc and sticky range error.
module modn_prog_counter
    import modn_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RST_MAX = 9
) (
    input  logic                clk,
    input  logic                reset,
    modn_prog_counter_if.slave  bus
);
    // RST_MAX only exists so older instantiations still elaborate.
    if (RST_MAX < 0) begin : g_rst_max_invalid
        $error("RST_MAX must be non-negative");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_count;
    logic             step_dir;
    logic             step_wrap;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    modn_step #(.WIDTH(WIDTH)) u_step (
        .count_i   (count_q),
        .dir_i     (dir_q),
        .mode_i    (mode),
        .max_val_i (bus.max_val),
        .count_o   (step_count),
        .dir_o     (step_dir),
        .wrap_o    (step_wrap)
    );

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        err_d   = err_q;
        if (bus.load) begin
            if (bus.load_val <= bus.max_val) begin
                count_d = bus.load_val;
                err_d   = 1'b0;
            end else begin
                count_d = '0;
                err_d   = 1'b1;
            end
        end else if (bus.en && mode != MODE_HOLD) begin
            count_d = step_count;
            dir_d   = step_dir;
            tc_d    = step_wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.tc    = tc_q;
    assign bus.err   = err_q;
endmodule
